// File: rtl/instruction_i_mc.sv
// Multi-cycle RV32I execution unit for OP-IMM, JALR and LOAD instructions.
// Loads read one 32-bit word from a RAM with an acknowledge and a bounded wait.
module instruction_i_mc #(
  parameter int ADDR_W  = 8,
  parameter int PC_W    = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iVALID,
  input  logic [31:0]       iIR,
  input  logic [31:0]       iREG_OUT1,
  input  logic [PC_W-1:0]   iPC,
  output logic              oBUSY,
  output logic              oDONE,
  output logic              oREG_WE,
  output logic [4:0]        oRD,
  output logic [4:0]        oRS1,
  output logic [31:0]       oREG_IN,
  output logic [31:0]       oPC,
  output logic              oPC_WE,
  output logic              oRAM_CE,
  output logic              oRAM_RD,
  output logic              oRAM_WR,
  output logic [ADDR_W-1:0] oRAM_ADDR,
  input  logic [31:0]       iRAM_DATA,
  input  logic              iRAM_ACK,
  output logic [1:0]        oEXC
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          f3_q, f3_d;
  logic [1:0]          off_q, off_d;
  logic [4:0]          rd_q, rd_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [31:0]         reg_in_q, reg_in_d;
  logic [31:0]         pc_q, pc_d;
  logic [4:0]          rd_out_q, rd_out_d;
  logic [1:0]          exc_q, exc_d;
  logic                jalr_q, jalr_d;

  logic [6:0]          opcode;
  logic [2:0]          f3;
  logic signed [31:0]  imm;
  logic [31:0]         ea;
  logic [31:0]         pc_ext;
  logic [4:0]          shamt;
  logic [31:0]         res;
  logic [1:0]          exc_n;
  logic                is_jalr;
  logic                go_wait;

  function automatic logic [31:0] load_extract(input logic [2:0]  fn3,
                                               input logic [1:0]  off,
                                               input logic [31:0] data);
    logic [7:0]  b;
    logic [15:0] h;
    b = data[{off, 3'b000} +: 8];
    h = off[1] ? data[31:16] : data[15:0];
    case (fn3)
      3'd0:    return {{24{b[7]}}, b};
      3'd4:    return {24'd0, b};
      3'd1:    return {{16{h[15]}}, h};
      3'd5:    return {16'd0, h};
      default: return data;
    endcase
  endfunction

  always_comb begin
    opcode = iIR[6:0];
    f3     = iIR[14:12];
    imm    = {{20{iIR[31]}}, iIR[31:20]};
    ea     = iREG_OUT1 + $unsigned(imm);
    shamt  = iIR[24:20];
    pc_ext = '0;
    pc_ext[PC_W-1:0] = iPC;

    res     = '0;
    exc_n   = 2'd0;
    is_jalr = 1'b0;
    go_wait = 1'b0;
    case (opcode)
      7'b0010011: begin
        case (f3)
          3'd0: res = ea;
          3'd1: if (iIR[31:25] == 7'h00) res = iREG_OUT1 << shamt;
                else exc_n = 2'd1;
          3'd2: res = {31'd0, $signed(iREG_OUT1) < imm};
          3'd3: res = {31'd0, iREG_OUT1 < $unsigned(imm)};
          3'd4: res = iREG_OUT1 ^ $unsigned(imm);
          3'd5: if (iIR[31:25] == 7'h00) res = iREG_OUT1 >> shamt;
                else if (iIR[31:25] == 7'h20) res = $unsigned($signed(iREG_OUT1) >>> shamt);
                else exc_n = 2'd1;
          3'd6: res = iREG_OUT1 | $unsigned(imm);
          default: res = iREG_OUT1 & $unsigned(imm);
        endcase
      end
      7'b1100111: begin
        if (f3 == 3'd0) begin
          is_jalr = 1'b1;
          res     = pc_ext + 32'd4;
        end else begin
          exc_n = 2'd1;
        end
      end
      7'b0000011: begin
        case (f3)
          3'd0, 3'd4: go_wait = 1'b1;
          3'd1, 3'd5: if (ea[0]) exc_n = 2'd2; else go_wait = 1'b1;
          3'd2:       if (ea[1:0] != 2'd0) exc_n = 2'd2; else go_wait = 1'b1;
          default:    exc_n = 2'd1;
        endcase
      end
      default: exc_n = 2'd1;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    f3_d       = f3_q;
    off_d      = off_q;
    rd_d       = rd_q;
    ram_addr_d = ram_addr_q;
    reg_in_d   = reg_in_q;
    pc_d       = pc_q;
    rd_out_d   = rd_out_q;
    exc_d      = exc_q;
    jalr_d     = jalr_q;
    case (state_q)
      S_IDLE: begin
        if (iVALID) begin
          f3_d  = f3;
          off_d = ea[1:0];
          rd_d  = iIR[11:7];
          if (go_wait) begin
            state_d    = S_WAIT;
            cnt_d      = '0;
            ram_addr_d = ea[ADDR_W+1:2];
          end else begin
            state_d  = S_DONE;
            reg_in_d = res;
            rd_out_d = iIR[11:7];
            exc_d    = exc_n;
            jalr_d   = is_jalr;
            if (is_jalr) pc_d = {ea[31:1], 1'b0};
          end
        end
      end
      S_WAIT: begin
        // The ack is checked first so that it wins in the last counted cycle.
        if (iRAM_ACK) begin
          state_d  = S_DONE;
          reg_in_d = load_extract(f3_q, off_q, iRAM_DATA);
          rd_out_d = rd_q;
          exc_d    = 2'd0;
          jalr_d   = 1'b0;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          state_d  = S_DONE;
          rd_out_d = rd_q;
          exc_d    = 2'd3;
          jalr_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ram_addr_q <= '0;
      reg_in_q   <= '0;
      pc_q       <= '0;
      rd_out_q   <= '0;
      exc_q      <= 2'd0;
      jalr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ram_addr_q <= ram_addr_d;
      reg_in_q   <= reg_in_d;
      pc_q       <= pc_d;
      rd_out_q   <= rd_out_d;
      exc_q      <= exc_d;
      jalr_q     <= jalr_d;
    end
    f3_q  <= f3_d;
    off_q <= off_d;
    rd_q  <= rd_d;
  end

  assign oBUSY     = (state_q != S_IDLE);
  assign oDONE     = (state_q == S_DONE);
  assign oREG_WE   = oDONE && (exc_q == 2'd0) && (rd_out_q != 5'd0);
  assign oPC_WE    = oDONE && (exc_q == 2'd0) && jalr_q;
  assign oRAM_CE   = (state_q == S_WAIT);
  assign oRAM_RD   = (state_q == S_WAIT);
  assign oRAM_WR   = 1'b0;
  assign oRAM_ADDR = ram_addr_q;
  assign oRD       = rd_out_q;
  assign oRS1      = iIR[19:15];
  assign oREG_IN   = reg_in_q;
  assign oPC       = pc_q;
  assign oEXC      = exc_q;

endmodule
